// File: rtl/memory_instruction.sv
// Instruction memory: combinational word fetch plus a streaming program-load port.
// Optional macro RVC_EN adds halfword-aligned fetch and the is_compressed output.
module memory_instruction #(
    parameter int    ADDR_WIDTH = 32,
    parameter int    INST_WIDTH = 32,
    parameter int    IMEM_DEPTH = 1024,
    parameter string INIT_FILE  = ""
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_WIDTH-1:0]       Address,
    output logic [INST_WIDTH-1:0]       instruction,
    output logic                        addr_fault,
    input  logic                        prog_valid,
    input  logic [INST_WIDTH-1:0]       prog_data,
    output logic                        prog_ready,
    output logic [$clog2(IMEM_DEPTH):0] prog_count
`ifdef RVC_EN
    ,
    output logic                        is_compressed
`endif
);

    localparam int IDXW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int CW   = $clog2(IMEM_DEPTH) + 1;
    localparam int WW   = ADDR_WIDTH - 2;
    localparam int HW   = INST_WIDTH / 2;
    localparam logic [WW-1:0]         DEPTH_W = WW'(IMEM_DEPTH);
    localparam logic [CW-1:0]         DEPTH_C = CW'(IMEM_DEPTH);
    localparam logic [INST_WIDTH-1:0] NOP     = INST_WIDTH'(32'h0000_0013);

    logic [INST_WIDTH-1:0] mem_q [IMEM_DEPTH];
    logic [CW-1:0]         ptr_q;
    logic [CW-1:0]         ptr_d;
    logic                  wr_en;
    logic [WW-1:0]         w;

    // Power-up image only; reset never touches the array.
    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            mem_q[i] = '0;
        end
    end

    assign prog_ready = !rst && (ptr_q < DEPTH_C);
    assign prog_count = ptr_q;

    always_comb begin
        wr_en = prog_valid && prog_ready;
        ptr_d = ptr_q;
        if (wr_en) begin
            ptr_d = ptr_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[ptr_q[IDXW-1:0]] <= prog_data;
        end
    end

    assign w = Address[ADDR_WIDTH-1:2];

`ifdef RVC_EN
    logic [WW-1:0] w1;
    logic [HW-1:0] upper;
    logic          unused_addr;

    assign w1          = w + WW'(1);
    assign unused_addr = Address[0];

    // A halfword fetch straddling the last word reads zeros for the missing half.
    always_comb begin
        instruction = NOP;
        addr_fault  = 1'b0;
        upper       = '0;
        if (!rst) begin
            if (w >= DEPTH_W) begin
                addr_fault = 1'b1;
            end else if (Address[1]) begin
                if (w1 < DEPTH_W) begin
                    upper = mem_q[w1[IDXW-1:0]][HW-1:0];
                end
                instruction = {upper, mem_q[w[IDXW-1:0]][INST_WIDTH-1:HW]};
            end else begin
                instruction = mem_q[w[IDXW-1:0]];
            end
        end
    end

    assign is_compressed = (instruction[1:0] != 2'b11);
`else
    logic unused_addr;

    assign unused_addr = ^Address[1:0];

    always_comb begin
        instruction = NOP;
        addr_fault  = 1'b0;
        if (!rst) begin
            if (w >= DEPTH_W) begin
                addr_fault = 1'b1;
            end else begin
                instruction = mem_q[w[IDXW-1:0]];
            end
        end
    end
`endif

endmodule

// File: tb/tb_memory_instruction.sv
// Randomized bench for memory_instruction against a word-array reference model.
module tb_memory_instruction;

    localparam int          D   = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] Address = 32'(4 * D);
    logic [31:0] instruction;
    logic        addr_fault;
    logic        prog_valid = 1'b0;
    logic [31:0] prog_data = '0;
    logic        prog_ready;
    logic [6:0]  prog_count;
`ifdef RVC_EN
    logic        is_compressed;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [D];
    int          model_ptr = 0;

    always #5 clk = ~clk;

    memory_instruction #(
        .ADDR_WIDTH(32),
        .INST_WIDTH(32),
        .IMEM_DEPTH(D),
        .INIT_FILE ("")
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Address      (Address),
        .instruction  (instruction),
        .addr_fault   (addr_fault),
        .prog_valid   (prog_valid),
        .prog_data    (prog_data),
        .prog_ready   (prog_ready),
        .prog_count   (prog_count)
`ifdef RVC_EN
        ,
        .is_compressed(is_compressed)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a plain array filled in order, pointer cleared by reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_ptr = 0;
        end else if (prog_valid && model_ptr < D) begin
            model_mem[model_ptr] = prog_data;
            model_ptr++;
        end
    end

    function automatic logic [31:0] exp_inst(input logic [31:0] a, input logic r);
        int unsigned w;
        logic [15:0] up;
        w = a >> 2;
        if (r || w >= D) return NOP;
`ifdef RVC_EN
        if (a[1]) begin
            up = (w + 1 < D) ? model_mem[w + 1][15:0] : 16'h0000;
            return {up, model_mem[w][31:16]};
        end
`endif
        up = 16'h0;
        return model_mem[w];
    endfunction

    always @(negedge clk) begin
        chk("instruction", instruction, exp_inst(Address, rst));
        chk("addr_fault", 32'(addr_fault), 32'(!rst && ((Address >> 2) >= D)));
        chk("prog_ready", 32'(prog_ready), 32'(!rst && model_ptr < D));
        chk("prog_count", 32'(prog_count), rst ? 32'd0 : 32'(model_ptr));
`ifdef RVC_EN
        chk("is_compressed", 32'(is_compressed), 32'(exp_inst(Address, rst) % 4 != 3));
`endif
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic probe(input string name, input logic [31:0] a,
                         input logic [31:0] exp_i, input logic exp_f);
        @(posedge clk);
        #1;
        Address = a;
        #1;
        chk({name, "_inst"}, instruction, exp_i);
        chk({name, "_fault"}, 32'(addr_fault), 32'(exp_f));
    endtask

    task automatic rand_phase(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            prog_valid = 1'($urandom_range(0, 1));
            prog_data  = $urandom;
            if ($urandom_range(0, 3) == 0) Address = $urandom;
            else Address = $urandom_range(0, 4 * D + 15);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < D; i++) model_mem[i] = '0;
        #1;
        chk("rst_inst", instruction, NOP);
        chk("rst_fault", 32'(addr_fault), 32'd0);
        chk("rst_ready", 32'(prog_ready), 32'd0);
        chk("rst_count", 32'(prog_count), 32'd0);

        step();
        rst        = 1'b0;
        Address    = 32'd0;
        prog_valid = 1'b1;
        prog_data  = 32'h0000_0091;
        @(negedge clk);
        #4;
        chk("rdw_old", instruction, 32'h0000_0000);
        @(posedge clk);
        #1;
        chk("rdw_new", instruction, 32'h0000_0091);
        #1;
        prog_data = 32'h0000_0086;
        step();
        prog_data = 32'h0070_0193;
        step();
        prog_valid = 1'b0;
        #1;
        chk("load3_count", 32'(prog_count), 32'd3);
        probe("w1", 32'd4, 32'h0000_0086, 1'b0);
        probe("w2", 32'd8, 32'h0070_0193, 1'b0);
        probe("w0", 32'd0, 32'h0000_0091, 1'b0);
        probe("a1", 32'd1, 32'h0000_0091, 1'b0);
`ifndef RVC_EN
        probe("a2", 32'd2, 32'h0000_0091, 1'b0);
`endif
        probe("oob", 32'(4 * D), NOP, 1'b1);
        probe("last", 32'(4 * D - 4), 32'h0000_0000, 1'b0);

        rand_phase(300);
        prog_valid = 1'b1;
        for (int k = 0; k < D + 2; k++) begin
            prog_data = $urandom;
            step();
        end
        #1;
        chk("full_count", 32'(prog_count), 32'(D));
        chk("full_ready", 32'(prog_ready), 32'd0);
        prog_valid = 1'b0;
        probe("full_w0", 32'd0, 32'h0000_0091, 1'b0);

        prog_valid = 1'b1;
        prog_data  = 32'hDEAD_BEEF;
        rst        = 1'b1;
        #1;
        chk("rst_full_count", 32'(prog_count), 32'd0);
        chk("rst_full_inst", instruction, NOP);
        chk("rst_full_ready", 32'(prog_ready), 32'd0);
        step();
        rst        = 1'b0;
        prog_valid = 1'b0;
        probe("kept_w0", 32'd0, 32'h0000_0091, 1'b0);

        prog_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            prog_data = 32'hA000_0000 + 32'(k);
            step();
        end
        prog_valid = 1'b0;
        #1;
        chk("midload_count", 32'(prog_count), 32'd5);
        rst = 1'b1;
        #1;
        chk("midrst_count", 32'(prog_count), 32'd0);
        chk("midrst_inst", instruction, NOP);
        step();
        rst = 1'b0;
        probe("reload_w0", 32'd0, 32'hA000_0000, 1'b0);
        probe("reload_w4", 32'd16, 32'hA000_0004, 1'b0);
        probe("kept_w5", 32'd20, model_mem[5], 1'b0);

        rand_phase(150);
        prog_valid = 1'b0;

`ifdef RVC_EN
        step();
        rst = 1'b1;
        step();
        rst        = 1'b0;
        prog_valid = 1'b1;
        prog_data  = 32'h0086_0091;
        step();
        prog_data = 32'h0000_0193;
        step();
        prog_valid = 1'b0;
        probe("rvc_half", 32'd2, 32'h0193_0086, 1'b0);
        chk("rvc_compressed", 32'(is_compressed), 32'd1);
        probe("rvc_edge", 32'(4 * D - 2), {16'h0000, model_mem[D - 1][31:16]}, 1'b0);
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
